// File: rtl/issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// issue_scheduler_if
//
// Bundle of signals between the reservation station / LSU side and the issue
// scheduler.
//
//   flush            RS -> sched  synchronous pipeline flush (branch mispredict)
//   req_valid        RS -> sched  entry i has operands ready and requests issue
//   req_is_mem       RS -> sched  entry i is a load/store (MEM port) when 1
//   mem_ready        LSU -> sched LSU accepts the pending MEM request this cycle
//   alu_issue_valid  sched -> EX  registered; an ALU op issues this cycle
//   alu_issue_idx    sched -> EX  registered; RS index of the issuing ALU op
//   mem_issue_valid  sched -> LSU registered; MEM request pending
//   mem_issue_idx    sched -> LSU registered; RS index of the pending MEM op
//   issue_ack        sched -> RS  combinational one-hot OR of issued entries
//
// Modports: master = RS/LSU side, slave = scheduler.
// -----------------------------------------------------------------------------
interface issue_scheduler_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = 3
);

   logic                   flush;
   logic [NUM_ENTRIES-1:0] req_valid;
   logic [NUM_ENTRIES-1:0] req_is_mem;
   logic                   mem_ready;
   logic                   alu_issue_valid;
   logic [IDX_W-1:0]       alu_issue_idx;
   logic                   mem_issue_valid;
   logic [IDX_W-1:0]       mem_issue_idx;
   logic [NUM_ENTRIES-1:0] issue_ack;

   modport master (
      output flush,
      output req_valid,
      output req_is_mem,
      output mem_ready,
      input  alu_issue_valid,
      input  alu_issue_idx,
      input  mem_issue_valid,
      input  mem_issue_idx,
      input  issue_ack
   );

   modport slave (
      input  flush,
      input  req_valid,
      input  req_is_mem,
      input  mem_ready,
      output alu_issue_valid,
      output alu_issue_idx,
      output mem_issue_valid,
      output mem_issue_idx,
      output issue_ack
   );

endinterface

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Per-cycle issue arbiter between the reservation station and the two
// execution ports. Each cycle it picks at most one ALU entry and one MEM entry,
// each with its own round-robin pointer. ALU grants are fire-and-forget; the
// MEM grant is held under a valid/ready handshake with the LSU.
//
// Ports:
//   clk   single clock, all state on the rising edge
//   rstn  asynchronous active-low reset
//   bus   issue_scheduler_if.slave (requests, grants, handshake, issue_ack)
//
// IDX_W must equal $clog2(NUM_ENTRIES).
// -----------------------------------------------------------------------------
module issue_scheduler #(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = 3
) (
   input  logic             clk,
   input  logic             rstn,
   issue_scheduler_if.slave bus
);

   typedef logic [NUM_ENTRIES-1:0] vec_t;
   typedef logic [IDX_W-1:0]       idx_t;

   // Single-bit encoding: WAIT is the flop value itself, so mem_issue_valid
   // comes straight off a register.
   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

   localparam logic [IDX_W:0] ENTRIES_W = (IDX_W+1)'(NUM_ENTRIES);

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   function automatic vec_t onehot(input idx_t k);
      vec_t v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic idx_t wrap_inc(input idx_t k);
      logic [IDX_W:0] nxt;
      nxt = {1'b0, k} + (IDX_W+1)'(1);
      if (nxt >= ENTRIES_W) nxt = '0;
      return nxt[IDX_W-1:0];
   endfunction

   // First set candidate at or above ptr, wrapping modulo NUM_ENTRIES.
   function automatic void rr_pick(input  vec_t cand,
                                   input  idx_t ptr,
                                   output logic found,
                                   output idx_t idx);
      logic [IDX_W:0] pos;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= ENTRIES_W) pos = pos - ENTRIES_W;
         if (!found && cand[pos[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = pos[IDX_W-1:0];
         end
      end
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic       alu_valid_q, alu_valid_d;
   idx_t       alu_idx_q,   alu_idx_d;
   idx_t       alu_ptr_q,   alu_ptr_d;
   mem_state_e mem_state_q, mem_state_d;
   idx_t       mem_idx_q,   mem_idx_d;
   idx_t       mem_ptr_q,   mem_ptr_d;

   // --------------------------------------------------------------------------
   // Acknowledge and candidate masks
   // --------------------------------------------------------------------------
   vec_t alu_ack;
   vec_t mem_ack;
   vec_t issue_ack;
   vec_t held_mem;
   vec_t alu_cand;
   vec_t mem_cand;
   logic alu_found;
   idx_t alu_sel;
   logic mem_found;
   idx_t mem_sel;

   assign alu_ack  = alu_valid_q ? onehot(alu_idx_q) : '0;
   assign mem_ack  = (mem_state_q == MEM_WAIT && bus.mem_ready) ? onehot(mem_idx_q) : '0;
   // A flushed cycle acknowledges nothing, even a completed MEM handshake.
   assign issue_ack = bus.flush ? '0 : (alu_ack | mem_ack);
   assign held_mem  = (mem_state_q == MEM_WAIT) ? onehot(mem_idx_q) : '0;

   // Entries being acked this cycle are still visible on req_valid; masking
   // them (and the held MEM entry) prevents issuing the same entry twice.
   assign alu_cand = bus.req_valid & ~bus.req_is_mem & ~issue_ack;
   assign mem_cand = bus.req_valid &  bus.req_is_mem & ~issue_ack & ~held_mem;

   always_comb begin
      rr_pick(alu_cand, alu_ptr_q, alu_found, alu_sel);
      rr_pick(mem_cand, mem_ptr_q, mem_found, mem_sel);
   end

   // --------------------------------------------------------------------------
   // Next state: ALU port and MEM handshake FSM
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; otherwise synthesis infers a latch.
      alu_valid_d = alu_found;
      alu_idx_d   = alu_found ? alu_sel : alu_idx_q;
      alu_ptr_d   = alu_found ? wrap_inc(alu_sel) : alu_ptr_q;
      mem_state_d = mem_state_q;
      mem_idx_d   = mem_idx_q;
      mem_ptr_d   = mem_ptr_q;

      case (mem_state_q)
         MEM_IDLE: begin
            if (mem_found) begin
               mem_idx_d   = mem_sel;
               mem_ptr_d   = wrap_inc(mem_sel);
               mem_state_d = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               if (mem_found) begin
                  // Back-to-back: load the next request in the handshake cycle.
                  mem_idx_d = mem_sel;
                  mem_ptr_d = wrap_inc(mem_sel);
               end else begin
                  mem_state_d = MEM_IDLE;
               end
            end
         end
         default: mem_state_d = MEM_IDLE;
      endcase

      // Flush wins over everything; pointers and indices are kept.
      if (bus.flush) begin
         alu_valid_d = 1'b0;
         alu_idx_d   = alu_idx_q;
         alu_ptr_d   = alu_ptr_q;
         mem_state_d = MEM_IDLE;
         mem_idx_d   = mem_idx_q;
         mem_ptr_d   = mem_ptr_q;
      end
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: the async reset clears every control register, so outputs and
      // issue_ack drop the moment rstn falls, with no clock edge needed.
      if (!rstn) begin
         alu_valid_q <= 1'b0;
         alu_idx_q   <= '0;
         alu_ptr_q   <= '0;
         mem_state_q <= MEM_IDLE;
         mem_idx_q   <= '0;
         mem_ptr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others, regardless of statement order.
         alu_valid_q <= alu_valid_d;
         alu_idx_q   <= alu_idx_d;
         alu_ptr_q   <= alu_ptr_d;
         mem_state_q <= mem_state_d;
         mem_idx_q   <= mem_idx_d;
         mem_ptr_q   <= mem_ptr_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.alu_issue_valid = alu_valid_q;
   assign bus.alu_issue_idx   = alu_idx_q;
   assign bus.mem_issue_valid = (mem_state_q == MEM_WAIT);
   assign bus.mem_issue_idx   = mem_idx_q;
   assign bus.issue_ack       = issue_ack;

endmodule
